// File: rtl/my_serial_adder_if.sv
// Handshake/data bundle for the bit-serial adder.
// master: requester drives start/a/b/cin; slave: adder drives busy/done/sum/cout.
interface my_serial_adder_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/my_serial_adder.sv
// Bit-serial ripple adder: one full-adder cell, one carry flop, LSB first.
// Ports: clk, rst_n (async low), bus (slave: start/a/b/cin in, busy/done/sum/cout out).
module my_serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    my_serial_adder_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic [WIDTH-1:0] shs_q, shs_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             s;
    logic             c;
    logic [WIDTH-1:0] shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            shs_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            shs_q   <= shs_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        shs_d   = shs_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        // Single full-adder cell on the current LSBs.
        s = sha_q[0] ^ shb_q[0] ^ carry_q;
        c = (sha_q[0] & shb_q[0]) | (sha_q[0] & carry_q) | (shb_q[0] & carry_q);

        // New sum bit enters at the MSB; after WIDTH shifts bit 0 is the LSB.
        shifted = shs_q >> 1;
        shifted[WIDTH-1] = s;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sha_d   = bus.a;
                    shb_d   = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                carry_d = c;
                sha_d   = sha_q >> 1;
                shb_d   = shb_q >> 1;
                shs_d   = shifted;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = shifted;
                    cout_d  = c;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q == ADD);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_my_serial_adder.sv
// Scoreboard bench for my_serial_adder (WIDTH=4): directed cases,
// exhaustive sweep and random ops against an arithmetic reference.
module tb_my_serial_adder;
    localparam int W = 4;

    logic clk;
    logic rst_n;

    my_serial_adder_if #(.WIDTH(W)) bus ();

    my_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;

    logic [W:0] sb_q[$];
    logic       prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: plain integer addition; {cout,sum} is the W+1-bit total.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, b, input logic c);
        int unsigned t;
        t = int'(a) + int'(b) + int'(c);
        return t[W:0];
    endfunction

    // Monitor: pops and compares on every done strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done) begin
                logic [W:0] e;
                chk("done_width", {31'd0, prev_done}, 32'd0);
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sum", {28'd0, bus.sum}, {28'd0, e[W-1:0]});
                    chk("cout", {31'd0, bus.cout}, {31'd0, e[W]});
                end
            end
            prev_done <= bus.done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    // Issues one op from IDLE; returns in the IDLE cycle after done.
    task automatic do_op(input logic [W-1:0] av, bv, input logic cv, input bit chk_lat);
        int lat;
        int nbusy;
        bus.start = 1'b1;
        bus.a = av;
        bus.b = bv;
        bus.cin = cv;
        sb_q.push_back(ref_add(av, bv, cv));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        nbusy = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) nbusy++;
            // operand changes during ADD must have no effect
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            bus.cin = 1'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        chk("done_seen", {31'd0, bus.done}, 32'd1);
        if (chk_lat) begin
            chk("latency", lat, W);
            chk("busy_cycles", nbusy, W);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_done", {31'd0, bus.done}, 0);
        chk("rst_sum", {28'd0, bus.sum}, 0);
        chk("rst_cout", {31'd0, bus.cout}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1..3 directed
        do_op(4'b0101, 4'b0011, 1'b0, 1'b1);
        do_op(4'b1111, 4'b0001, 1'b0, 1'b1);
        do_op(4'b1111, 4'b1111, 1'b1, 1'b1);
        do_op(4'b0000, 4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            @(posedge clk);
            #1;
            chk("hold_sum", {28'd0, bus.sum}, 32'd1);
            chk("hold_cout", {31'd0, bus.cout}, 0);
        end

        // 4: starts during ADD and DONE are ignored
        bus.start = 1'b1;
        bus.a = 4'd3;
        bus.b = 4'd4;
        bus.cin = 1'b0;
        sb_q.push_back(ref_add(4'd3, 4'd4, 1'b0));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a = 4'd9;
        bus.b = 4'd9;
        bus.cin = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        begin
            int t = 0;
            while (!bus.done && t < 20) begin
                @(posedge clk);
                #1;
                t++;
            end
        end
        chk("t4_done", {31'd0, bus.done}, 1);
        bus.start = 1'b1;
        bus.a = 4'd15;
        bus.b = 4'd14;
        bus.cin = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_idle_busy", {31'd0, bus.busy}, 0);
        chk("t4_idle_done", {31'd0, bus.done}, 0);
        bus.start = 1'b0;
        do_op(4'd6, 4'd5, 1'b1, 1'b1);

        // 5: async reset mid-add
        bus.start = 1'b1;
        bus.a = 4'd7;
        bus.b = 4'd2;
        bus.cin = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 0);
        chk("abort_done", {31'd0, bus.done}, 0);
        chk("abort_sum", {28'd0, bus.sum}, 0);
        chk("abort_cout", {31'd0, bus.cout}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        begin
            int nd = 0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                #1;
                if (bus.done) nd++;
            end
            chk("abort_no_done", nd, 0);
        end
        do_op(4'd10, 4'd7, 1'b0, 1'b1);

        // 6: exhaustive sweep
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            do_op(v[3:0], v[7:4], v[8], 1'b0);
        end

        // randomized ops, including back-to-back
        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
